// File: rtl/tns_enc_21_pkg.sv
// Shared definitions for the 21-bit TNS encoder: word width, per-group
// weights, the default admissible-symbol mask, FSM states and helpers.
package tns_enc_21_pkg;

  // Binary word width and the wider width used for symbol values before
  // they are compared against the remainder.
  localparam int BLEN07 = 19;
  localparam int VLEN   = BLEN07 + 2;

  // Codeword geometry: 7 groups of {A,B,C}.
  localparam int NGRP_FIXED = 7;
  localparam int CODE_W     = 3 * NGRP_FIXED;

  // 3C1S line code forbids the isolated-B (010) and split A/C (101) symbols.
  localparam logic [7:0] TNS_3C1S_SYM_MASK = 8'hDB;

  typedef logic [BLEN07-1:0] word_t;
  typedef logic [VLEN-1:0]   wide_t;

  // Group weights. Group n scales by 6^(n-1); within a group A=3, B=1, C=1,
  // so the admissible symbols take the distinct values 0..5 and the code is
  // a mixed base-6 representation.
  localparam word_t TNS01_A = BLEN07'(3);
  localparam word_t TNS01_B = BLEN07'(1);
  localparam word_t TNS01_C = BLEN07'(1);
  localparam word_t TNS02_A = BLEN07'(18);
  localparam word_t TNS02_B = BLEN07'(6);
  localparam word_t TNS02_C = BLEN07'(6);
  localparam word_t TNS03_A = BLEN07'(108);
  localparam word_t TNS03_B = BLEN07'(36);
  localparam word_t TNS03_C = BLEN07'(36);
  localparam word_t TNS04_A = BLEN07'(648);
  localparam word_t TNS04_B = BLEN07'(216);
  localparam word_t TNS04_C = BLEN07'(216);
  localparam word_t TNS05_A = BLEN07'(3888);
  localparam word_t TNS05_B = BLEN07'(1296);
  localparam word_t TNS05_C = BLEN07'(1296);
  localparam word_t TNS06_A = BLEN07'(23328);
  localparam word_t TNS06_B = BLEN07'(7776);
  localparam word_t TNS06_C = BLEN07'(7776);
  localparam word_t TNS07_A = BLEN07'(139968);
  localparam word_t TNS07_B = BLEN07'(46656);
  localparam word_t TNS07_C = BLEN07'(46656);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } tns_state_e;

  // Weight lookups indexed by group index (0 = group 1 ... 6 = group 7).
  function automatic word_t tns_w_a(input logic [2:0] grp);
    case (grp)
      3'd0:    return TNS01_A;
      3'd1:    return TNS02_A;
      3'd2:    return TNS03_A;
      3'd3:    return TNS04_A;
      3'd4:    return TNS05_A;
      3'd5:    return TNS06_A;
      3'd6:    return TNS07_A;
      default: return '0;
    endcase
  endfunction

  function automatic word_t tns_w_b(input logic [2:0] grp);
    case (grp)
      3'd0:    return TNS01_B;
      3'd1:    return TNS02_B;
      3'd2:    return TNS03_B;
      3'd3:    return TNS04_B;
      3'd4:    return TNS05_B;
      3'd5:    return TNS06_B;
      3'd6:    return TNS07_B;
      default: return '0;
    endcase
  endfunction

  function automatic word_t tns_w_c(input logic [2:0] grp);
    case (grp)
      3'd0:    return TNS01_C;
      3'd1:    return TNS02_C;
      3'd2:    return TNS03_C;
      3'd3:    return TNS04_C;
      3'd4:    return TNS05_C;
      3'd5:    return TNS06_C;
      3'd6:    return TNS07_C;
      default: return '0;
    endcase
  endfunction

  // Value of symbol {a,b,c}, evaluated at the wide width so that a sum of
  // three full-width weights cannot wrap.
  function automatic wide_t sym_value(input logic [2:0] sym, input word_t w_a,
                                      input word_t w_b, input word_t w_c);
    wide_t v;
    v = '0;
    if (sym[2]) v = v + {2'b00, w_a};
    if (sym[1]) v = v + {2'b00, w_b};
    if (sym[0]) v = v + {2'b00, w_c};
    return v;
  endfunction

endpackage

// File: rtl/tns_enc_21_if.sv
// Encoder streaming interface.
//
// Handshake: both sides use valid/ready. A word moves on a rising clk edge
// where valid and ready are both high. Once valid is raised by a source it
// is held, with its data stable, until that edge; ready may be raised or
// dropped at any time and never depends on valid.
interface tns_enc_21_if;
  import tns_enc_21_pkg::*;

  logic [BLEN07-1:0] datain;
  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] codeout;
  logic              out_valid;
  logic              out_ready;
  logic              enc_err;

  // Encoder side.
  modport slave (
    input  datain, in_valid, out_ready,
    output in_ready, codeout, out_valid, enc_err
  );

  // Producer/consumer side.
  modport master (
    output datain, in_valid, out_ready,
    input  in_ready, codeout, out_valid, enc_err
  );
endinterface

// File: rtl/tns_enc_21_grp_sel.sv
// Greedy symbol chooser for one group: picks the admissible symbol with the
// largest value not exceeding the remainder; ties go to the lower index.
module tns_enc_21_grp_sel
  import tns_enc_21_pkg::*;
(
  input  word_t      rem_i,
  input  word_t      w_a_i,
  input  word_t      w_b_i,
  input  word_t      w_c_i,
  input  logic [7:0] sym_mask_i,
  output logic [2:0] sym_o,
  output word_t      val_o
);

  wide_t      cand_v;
  logic [2:0] cand_s;

  // Scan symbols upward; a strictly greater value is needed to replace the
  // current best, which leaves ties on the lower index. Symbol 000 is the
  // fallback and is always admissible.
  always_comb begin
    sym_o  = 3'b000;
    val_o  = '0;
    cand_v = '0;
    cand_s = 3'b000;
    for (int s = 1; s < 8; s++) begin
      cand_s = 3'(s);
      cand_v = sym_value(cand_s, w_a_i, w_b_i, w_c_i);
      if (sym_mask_i[cand_s] && (cand_v <= {2'b00, rem_i}) &&
          (cand_v > {2'b00, val_o})) begin
        sym_o = cand_s;
        // Fits in the narrow width because it does not exceed rem_i.
        val_o = cand_v[BLEN07-1:0];
      end
    end
  end

endmodule

// File: rtl/tns_enc_21.sv
// Group-serial binary-to-TNS encoder. Accepts one word, resolves group 7
// down to group 1 one group per cycle, then holds the codeword until the
// consumer takes it.
module tns_enc_21
  import tns_enc_21_pkg::*;
#(
  parameter logic [7:0] SYM_MASK = TNS_3C1S_SYM_MASK,
  parameter int         NGRP     = NGRP_FIXED
) (
  input  logic        clk,
  input  logic        rst_n,
  tns_enc_21_if.slave bus,
  output tns_state_e  state_o
);

  tns_state_e        state_q, state_d;
  word_t             rem_q, rem_d;
  logic [2:0]        grp_q, grp_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] codeout_q, codeout_d;
  logic              out_valid_q, out_valid_d;
  logic              enc_err_q, enc_err_d;

  logic [2:0] sel_sym;
  word_t      sel_val;
  word_t      w_a, w_b, w_c;

  // Weights of the group currently being resolved.
  assign w_a = tns_w_a(grp_q);
  assign w_b = tns_w_b(grp_q);
  assign w_c = tns_w_c(grp_q);

  tns_enc_21_grp_sel u_grp_sel (
    .rem_i      (rem_q),
    .w_a_i      (w_a),
    .w_b_i      (w_b),
    .w_c_i      (w_c),
    .sym_mask_i (SYM_MASK),
    .sym_o      (sel_sym),
    .val_o      (sel_val)
  );

  // in_ready is gated by rst_n so the encoder never advertises space while
  // it is being reset; outputs come straight from registers.
  assign bus.in_ready  = rst_n && (state_q == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.codeout   = codeout_q;
  assign bus.enc_err   = enc_err_q;
  assign state_o       = state_q;

  // Next-state logic: capture, per-group greedy step, and output hold.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    grp_d       = grp_q;
    code_d      = code_q;
    codeout_d   = codeout_q;
    out_valid_d = out_valid_q;
    enc_err_d   = enc_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          rem_d   = bus.datain;
          code_d  = '0;
          grp_d   = 3'(NGRP - 1);
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        code_d[int'(grp_q) * 3 +: 3] = sel_sym;
        rem_d = rem_q - sel_val;
        if (grp_q == 3'd0) begin
          // Register the result together with entering DONE so out_valid,
          // codeout and enc_err all change on the same edge.
          state_d     = ST_DONE;
          out_valid_d = 1'b1;
          codeout_d   = code_d;
          enc_err_d   = (rem_d != '0);
        end else begin
          grp_d = grp_q - 3'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      grp_q       <= 3'd0;
      code_q      <= '0;
      codeout_q   <= '0;
      out_valid_q <= 1'b0;
      enc_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      grp_q       <= grp_d;
      code_q      <= code_d;
      codeout_q   <= codeout_d;
      out_valid_q <= out_valid_d;
      enc_err_q   <= enc_err_d;
    end
  end

  // Group index always addresses a slot inside the codeword.
  a_grp_range: assert property (@(posedge clk) disable iff (!rst_n)
    grp_q < 3'(NGRP));

  // Only admissible symbols are ever written into the codeword.
  a_sym_allowed: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ST_CONV) |-> ((sel_sym == 3'b000) || SYM_MASK[sel_sym]));

  // out_valid is high exactly while the FSM sits in DONE.
  a_valid_done: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q == (state_q == ST_DONE));

endmodule

// File: doc/tns_enc_21.md
Name: tns_enc_21

Overview:
- Sequential encoder from a binary word of width `BLEN07 to a 21-bit TNS codeword: 7 groups of 3 bits, each bit weighted by `TNSnn_A/B/C.
- Exact inverse of the team's 21-bit TNS decoder, which computes dataout = weighted sum of the codeword bits.
- Sits on the transmit side of the 3C1S link, ahead of the bus drivers.
- Greedy, group-serial conversion (group 7 down to group 1, one group per cycle) with valid/ready on both sides.

Parameters:
- SYM_MASK, 8'hDB: admissible 3-bit group symbols; bit s set means symbol s={a,b,c} is allowed. Default allows 000,001,011,100,110,111 and forbids 010 and 101.
- NGRP, 7: number of groups. Fixed at 7, present for assertions only.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: synchronous active-low reset.
- datain, in, `BLEN07: binary value to encode.
- in_valid, in, 1: datain is valid.
- in_ready, out, 1: encoder can accept a word.
- codeout, out, 21: codeword. Bit layout: [20:18]=group 7 {A,B,C} down to [2:0]=group 1.
- out_valid, out, 1: codeout and enc_err are valid.
- out_ready, in, 1: consumer accepts the word.
- enc_err, out, 1: input not exactly representable (remainder nonzero after group 1).

Behaviour:
- Reset: synchronous, active-low, on clk rising edge only.
  - Outputs: in_ready=0 during reset, 1 in the first cycle after reset. out_valid=0, codeout=0, enc_err=0.
  - Internal: rem=0, grp=0, FSM=IDLE.
- Reset asserted mid-conversion aborts the conversion immediately. The partial codeword is discarded; nothing is emitted.
- FSM states IDLE, CONV, DONE.
  - IDLE: in_ready=1. When in_valid&in_ready: rem<=datain, code<=0, grp<=6 (index of group 7), go to CONV.
  - CONV: in_ready=0. Each cycle:
    - tns_grp_sel selects, for group grp, the allowed symbol s maximising v(s)=a*W_A+b*W_B+c*W_C subject to v(s)<=rem.
    - Ties resolve to the lower symbol index. Symbol 000 (value 0) always qualifies.
    - code[3*grp+2:3*grp]<=s; rem<=rem-v(s).
    - If grp==0, go to DONE; otherwise grp<=grp-1.
  - DONE: out_valid=1; codeout=code; enc_err=(rem!=0). These are held stable while out_ready=0.
    - On out_valid&out_ready: go to IDLE and out_valid<=0. codeout keeps its last value.
- Latency: accept handshake at cycle T; out_valid rises at T+8 (7 CONV cycles + DONE register).
- Throughput: one word per 9 cycles minimum. No overlap: in_ready=0 from T+1 until the cycle after the output handshake.
- Arithmetic:
  - rem and v(s) are `BLEN07 bits, unsigned.
  - The subtraction never underflows because v(s)<=rem.
  - v(s) is computed at `BLEN07+2 bits before the compare, so no truncation occurs.
- Out-of-range datain (greater than the maximum weighted sum of allowed symbols): greedy still runs, codeout is the best-effort codeword, enc_err=1. No hang, no wrap.
- Invariant when enc_err=0: weighted sum of codeout == datain captured at T.
- in_valid while not in_ready: ignored. datain is not sampled.
- Simultaneous out_ready and in_valid in DONE: the output handshake completes; the input is accepted the next cycle (IDLE).

Decomposition:
- Shared header TNS.vh (extend):
  - `TNS01..07_A/B/C weights and `BLEN07.
  - 7-entry weight lookup macros indexed by group.
  - Default SYM_MASK value `TNS_3C1S_SYM_MASK.
  - FSM state encodings.
- Sub-module tns_grp_sel: combinational. Inputs rem, W_A, W_B, W_C, SYM_MASK. Outputs sym[2:0], val.

Test Plan:
- datain=0 -> out_valid at T+8, codeout=21'h0, enc_err=0.
- datain=`TNS07_A -> codeout=21'h100000 (bit 20 only), enc_err=0. Repeat for `TNS01_C -> codeout=21'h000001 when no higher allowed symbol has equal weight.
- Random 2000 datain below the max representable value, with random out_ready backpressure (0–5 stall cycles) -> weighted-sum golden model equals datain and enc_err=0. Every group symbol is in SYM_MASK. codeout is stable while out_valid&!out_ready.
- datain = all-ones `BLEN07 when it exceeds the max sum -> enc_err=1, out_valid still at T+8, FSM returns to IDLE after out_ready.
- rst_n=0 at T+4 mid-conversion -> next cycle out_valid=0, codeout=0, in_ready=1. A new datain=`TNS04_B then encodes correctly with no residue from the aborted word.
- Back-to-back: in_valid held high, out_ready=1 -> in_ready pulses every 9 cycles, no word lost or duplicated (scoreboard count match).
